// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial N-bit subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Valid/ready on both sides; result registers hold the last result until the next one completes.
//
//   state | meaning
//   IDLE  | ready for operands; diff/bout hold the last result
//   SHIFT | one difference bit per edge, N edges total
//   DONE  | out_valid high; waits for out_ready
module serial_subtractor_n_bit #(
    parameter  int N     = 3,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     sa_q, sa_d;
    logic [N-1:0]     sb_q, sb_d;
    logic             br_q, br_d;
    logic [N-1:0]     res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             d_bit;
    logic             br_nxt;
    logic [N-1:0]     res_shift;

    always_comb begin
        d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
        br_nxt    = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        // new bit enters at the MSB so the LSB-first stream lands in place after N shifts
        res_shift        = res_q >> 1;
        res_shift[N-1]   = d_bit;

        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_nxt;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    diff_d  = res_shift;
                    bout_d  = br_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule
